vedic_mult_pipe: RTL and testbench
==================================

Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier.
- Multiplies two WIDTH-bit operands and produces a 2*WIDTH-bit product.
- Built recursively: 2x2 leaf products first, then one combine level per pipeline stage.
- Sits between upstream operand sources and downstream consumers behind a valid/ready handshake, with stall support and an in-flight counter.

Parameters:
- WIDTH, 16: operand width. Must be a power of two, >= 2. Any other value is a fatal elaboration error.
- LAT, log2(WIDTH) (derived, not overridable): pipeline depth in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- p  out  2*WIDTH  product.
- inflight  out  clog2(LAT+1)  number of accepted transactions not yet delivered.

Behaviour:
- Reset: all stage valid bits 0, all data registers 0, inflight = 0, out_valid = 0, p = 0. A reset asserted mid-operation discards every in-flight item; nothing is delivered after reset releases.
- Global enable: en = out_ready | ~out_valid. in_ready = en. When en = 1, every stage advances one position; when en = 0, every stage holds.
- Bubbles are not collapsed while stalled.
- Accept: a transfer happens when in_valid & in_ready. The stage-1 valid bit loads in_valid & en.
- Stage 1 registers (WIDTH/2)^2 4-bit leaf products of 2-bit digit pairs.
- Stage k (2..LAT) combines groups of four width-w sub-products into one 2w-bit product: P = LL + ((LH + HL) << w/2) + (HH << w), computed at full width with no truncation.
- The final stage register drives p directly; p is registered with no combinational path from a or b.
- Latency: exactly LAT cycles from accept to out_valid, with out_ready held high.
- Throughput: one product per cycle when not stalled.
- Output handshake: p and out_valid hold stable while out_valid & ~out_ready.
- inflight update each cycle: +1 on accept, -1 on out_valid & out_ready, unchanged on both or neither. It never exceeds LAT.
- WIDTH=2 case: LAT=1; the single stage is the leaf register.
- X on a or b while in_valid = 0 must not propagate to out_valid.

Optional Feature:
- Macro: VEDIC_MULT_SIGNED_EN.
- Defined:
  - Extra input port in_signed (1 bit), sampled with a and b on accept.
  - When in_signed = 1, operands are two's complement. Magnitudes are formed before stage 1.
  - The sign (a[MSB] ^ b[MSB]) travels down the pipe with the valid bit.
  - The product is negated inside the last stage before its register. Latency is unchanged.
  - A magnitude of 2^(WIDTH-1) is handled correctly.
  - When in_signed = 0, behaviour is unsigned.
- Undefined: the in_signed port is absent; all operands are unsigned.

Decomposition:
- Package vedic_pkg holds:
  - the constant function clog2;
  - a stage-count function lat_of(width);
  - the leaf width constant LEAF_W = 2.
- Leaf products use the team's existing vedic_2x2 cell, instantiated via generate.
- One sub-module, vedic_combine (parameter W): combinational four-input combine producing a 2W-bit result. vedic_mult_pipe owns all registers, valids and the counter.

Test Plan:
1. WIDTH=16, out_ready=1: a=0xFFFF, b=0xFFFF -> out_valid 4 cycles after accept, p=0xFFFE0001, inflight 1->0.
2. Back-to-back stream of 4 pairs (0x0003*0x0005, 0x1234*0x0010, 0x8000*0x0002, 0x0000*0xABCD) -> p = 0x0000000F, 0x00012340, 0x00010000, 0x00000000 on consecutive cycles, in order.
3. Stall: fill 4 items, out_ready=0 for 6 cycles -> in_ready=0, p and out_valid stable, inflight=4; release -> all 4 delivered in order.
4. Reset mid-flight: assert rst_n=0 with inflight=3 -> out_valid=0, p=0, inflight=0 immediately; no stale output after release.
5. WIDTH=2 and WIDTH=8 builds: exhaustive and random operands respectively -> matches reference a*b with latency 1 and 3.
6. VEDIC_MULT_SIGNED_EN, WIDTH=16, in_signed=1:
   - 0xFFFD*0x0005 -> 0xFFFFFFF1.
   - 0x8000*0x8000 -> 0x40000000.
   - With in_signed=0, 0xFFFD*0x0005 -> 0x0004FFF1.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared constants and elaboration-time helpers for the Vedic multiplier.
package vedic_pkg;

    // Width of one leaf digit; leaf products are LEAF_W x LEAF_W.
    localparam int LEAF_W = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Pipeline depth: one leaf stage plus one combine stage per doubling.
    function automatic int lat_of(input int unsigned width);
        return clog2(width);
    endfunction

endpackage

// File: rtl/vedic_2x2.sv
// 2x2 Urdhva-Tiryagbhyam leaf cell: 2-bit by 2-bit unsigned product.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic cross_c;

    // Vertical and crosswise partial products, gate-level form.
    always_comb begin
        cross_c = (a[1] & b[0]) & (a[0] & b[1]);
        p[0]    = a[0] & b[0];
        p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
        p[2]    = (a[1] & b[1]) ^ cross_c;
        p[3]    = (a[1] & b[1]) & cross_c;
    end

endmodule

// File: rtl/vedic_combine.sv
// Combines four W-bit sub-products of half-width chunks into one 2W-bit product.
module vedic_combine #(
    parameter int W = 4
) (
    input  logic [W-1:0]   ll,
    input  logic [W-1:0]   lh,
    input  logic [W-1:0]   hl,
    input  logic [W-1:0]   hh,
    output logic [2*W-1:0] p
);

    localparam int H = W / 2;

    // P = LL + ((LH + HL) << W/2) + (HH << W) at full 2W width.
    always_comb begin
        p = {{W{1'b0}}, ll}
          + (({{W{1'b0}}, lh} + {{W{1'b0}}, hl}) << H)
          + {hh, {W{1'b0}}};
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined Vedic multiplier with valid/ready handshake and in-flight counter.
// Optional signed mode: define VEDIC_MULT_SIGNED_EN to add the in_signed port.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
`ifdef VEDIC_MULT_SIGNED_EN
    input  logic                                   in_signed,
`endif
    input  logic [WIDTH-1:0]                       a,
    input  logic [WIDTH-1:0]                       b,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [2*WIDTH-1:0]                     p,
    output logic [clog2(lat_of(WIDTH)+1)-1:0]      inflight
);

    localparam int LAT = lat_of(WIDTH);
    localparam int IFW = clog2(LAT + 1);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "vedic_mult_pipe: WIDTH must be a power of two >= 2");
    end

    logic           en;
    logic           accept;
    logic           deliver;
    logic [LAT:1]   valid_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign out_valid = valid_q[LAT];
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign accept    = in_valid & en;
    assign deliver   = out_valid & out_ready;

`ifdef VEDIC_MULT_SIGNED_EN
    logic sign_in;
    logic neg_sel;

    // Operand magnitudes; negating 2^(WIDTH-1) yields itself, the correct magnitude.
    always_comb begin
        a_mag   = (in_signed & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag   = (in_signed & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        sign_in = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // Sign rides alongside the data up to the stage feeding the last register.
    if (LAT > 1) begin : g_sign
        logic [LAT-1:1] sign_q;

        // Sign shift register, advancing with the global enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sign_q <= '0;
            end else if (en) begin
                sign_q[1] <= in_valid & sign_in;
                for (int unsigned s = 2; s <= LAT - 1; s++) begin
                    sign_q[s] <= sign_q[s-1];
                end
            end
        end

        assign neg_sel = sign_q[LAT-1];
    end else begin : g_sign_leaf
        assign neg_sel = sign_in;
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Stage valid bits; bubbles are held in place while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q[1] <= in_valid;
            for (int unsigned s = 2; s <= LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    // Level k holds products of (2^k)-bit chunks: N x N products of 2^(k+1) bits.
    for (genvar k = 1; k <= LAT; k++) begin : g_lvl
        localparam int CW = 1 << k;
        localparam int N  = WIDTH / CW;
        localparam int PW = 2 * CW;

        logic [PW-1:0] raw    [N*N];
        logic [PW-1:0] nxt    [N*N];
        logic [PW-1:0] prod_q [N*N];

        for (genvar i = 0; i < N; i++) begin : g_row
            for (genvar j = 0; j < N; j++) begin : g_col
                if (k == 1) begin : g_leaf
                    vedic_2x2 u_leaf (
                        .a (a_mag[i*LEAF_W +: LEAF_W]),
                        .b (b_mag[j*LEAF_W +: LEAF_W]),
                        .p (raw[i*N+j])
                    );
                end else begin : g_comb
                    // Previous level is 2N x 2N; index [a_chunk * 2N + b_chunk].
                    vedic_combine #(.W(CW)) u_comb (
                        .ll (g_lvl[k-1].prod_q[(2*i)*(2*N) + 2*j]),
                        .lh (g_lvl[k-1].prod_q[(2*i)*(2*N) + 2*j + 1]),
                        .hl (g_lvl[k-1].prod_q[(2*i+1)*(2*N) + 2*j]),
                        .hh (g_lvl[k-1].prod_q[(2*i+1)*(2*N) + 2*j + 1]),
                        .p  (raw[i*N+j])
                    );
                end
            end
        end

`ifdef VEDIC_MULT_SIGNED_EN
        if (k == LAT) begin : g_neg
            // Two's-complement negate of the full product ahead of the output register.
            always_comb begin
                nxt = raw;
                if (neg_sel) nxt[0] = ~raw[0] + PW'(1);
            end
        end else begin : g_pass
            assign nxt = raw;
        end
`else
        assign nxt = raw;
`endif

        // Level register: leaf level loads only on accept, later levels on enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned x = 0; x < N*N; x++) prod_q[x] <= '0;
            end else if ((k == 1) ? accept : en) begin
                for (int unsigned x = 0; x < N*N; x++) prod_q[x] <= nxt[x];
            end
        end
    end

    assign p = g_lvl[LAT].prod_q[0];

    // Accepted-but-undelivered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({accept, deliver})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed self-checking bench for vedic_mult_pipe (WIDTH 16, 8 and 2 instances).
module tb_vedic_mult_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b;
    logic [31:0] p;
    logic [2:0]  inflight;
    logic        in_signed;

    logic        v8, r8, ov8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic [1:0]  if8;

    logic        v2, r2, ov2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic [0:0]  if2;

    int n_checks;
    int n_fail;

    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [31:0] vp [4];
    logic [7:0]  wa [4];
    logic [7:0]  wb [4];
    logic [15:0] wp [4];

    vedic_mult_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
`ifdef VEDIC_MULT_SIGNED_EN
        .in_signed(in_signed),
`endif
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .inflight(inflight)
    );

    vedic_mult_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
`ifdef VEDIC_MULT_SIGNED_EN
        .in_signed(1'b0),
`endif
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(1'b1),
        .p(p8), .inflight(if8)
    );

    vedic_mult_pipe #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
`ifdef VEDIC_MULT_SIGNED_EN
        .in_signed(1'b0),
`endif
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(1'b1),
        .p(p2), .inflight(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_signed = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; v2 = 1'b0; a2 = '0; b2 = '0;

        // Reset state
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p",         64'(p),         64'd0);
        check("rst_inflight",  64'(inflight),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid8", 64'(ov8), 64'd0);
        check("rst_out_valid2", 64'(ov2), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: single FFFF*FFFF, latency 4
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        check("t1_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("t1_inflight_1", 64'(inflight), 64'd1);
        check("t1_ov_c1", 64'(out_valid), 64'd0);
        step(); check("t1_ov_c2", 64'(out_valid), 64'd0);
        step(); check("t1_ov_c3", 64'(out_valid), 64'd0);
        step();
        check("t1_ov_c4",     64'(out_valid), 64'd1);
        check("t1_p",         64'(p),         64'hFFFE0001);
        check("t1_inflight4", 64'(inflight),  64'd1);
        step();
        check("t1_ov_after", 64'(out_valid), 64'd0);
        check("t1_inflight0", 64'(inflight), 64'd0);

        // 2: back-to-back stream
        va = '{16'h0003, 16'h1234, 16'h8000, 16'h0000};
        vb = '{16'h0005, 16'h0010, 16'h0002, 16'hABCD};
        vp = '{32'h0000000F, 32'h00012340, 32'h00010000, 32'h00000000};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                a = va[i]; b = vb[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 3 && i < 7) begin
                check("t2_ov", 64'(out_valid), 64'd1);
                check("t2_p",  64'(p),         64'(vp[i-3]));
            end
        end
        check("t2_ov_end", 64'(out_valid), 64'd0);
        check("t2_inflight_end", 64'(inflight), 64'd0);

        // 3: stall with full pipe
        va = '{16'h0002, 16'h0100, 16'hFFFF, 16'h00FF};
        vb = '{16'h0003, 16'h0100, 16'h0001, 16'h00FF};
        vp = '{32'h00000006, 32'h00010000, 32'h0000FFFF, 32'h0000FE01};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; in_valid = 1'b1;
            step();
        end
        a = 16'h0007; b = 16'h0007;
        for (int i = 0; i < 6; i++) begin
            check("t3_in_ready", 64'(in_ready),  64'd0);
            check("t3_ov",       64'(out_valid), 64'd1);
            check("t3_p",        64'(p),         64'(vp[0]));
            check("t3_inflight", 64'(inflight),  64'd4);
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            check("t3_drain_ov", 64'(out_valid), 64'd1);
            check("t3_drain_p",  64'(p),         64'(vp[i]));
        end
        step();
        check("t3_ov_end", 64'(out_valid), 64'd0);
        check("t3_inflight_end", 64'(inflight), 64'd0);

        // 4: reset with three items in flight
        for (int i = 0; i < 3; i++) begin
            a = 16'h0101; b = 16'h0202; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("t4_inflight3", 64'(inflight), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_ov",       64'(out_valid), 64'd0);
        check("t4_rst_p",        64'(p),         64'd0);
        check("t4_rst_inflight", 64'(inflight),  64'd0);
        step();
        rst_n = 1'b1;
        a = 'x; b = 'x;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_no_stale_ov", 64'(out_valid), 64'd0);
            check("t4_no_stale_if", 64'(inflight),  64'd0);
        end
        a = '0; b = '0;

        // 5a: WIDTH=2 exhaustive, latency 1
        for (int i = 0; i < 16; i++) begin
            a2 = 2'(i >> 2); b2 = 2'(i); v2 = 1'b1;
            step();
            check("t5_w2_ov", 64'(ov2), 64'd1);
            check("t5_w2_p",  64'(p2),  64'(4'(a2) * 4'(b2)));
        end
        v2 = 1'b0;
        step();
        check("t5_w2_ov_end", 64'(ov2), 64'd0);

        // 5b: WIDTH=8 directed, latency 3
        wa = '{8'hFF, 8'h80, 8'h12, 8'h0F};
        wb = '{8'hFF, 8'h80, 8'h34, 8'h10};
        wp = '{16'hFE01, 16'h4000, 16'h03A8, 16'h00F0};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                a8 = wa[i]; b8 = wb[i]; v8 = 1'b1;
            end else begin
                v8 = 1'b0;
            end
            step();
            if (i < 2) check("t5_w8_ov_early", 64'(ov8), 64'd0);
            if (i >= 2 && i < 6) begin
                check("t5_w8_ov", 64'(ov8), 64'd1);
                check("t5_w8_p",  64'(p8),  64'(wp[i-2]));
            end
        end
        check("t5_w8_ov_end", 64'(ov8), 64'd0);

`ifdef VEDIC_MULT_SIGNED_EN
        // 6: signed mode
        va = '{16'hFFFD, 16'h8000, 16'hFFFD, 16'h8000};
        vb = '{16'h0005, 16'h8000, 16'h0005, 16'h0001};
        vp = '{32'hFFFFFFF1, 32'h40000000, 32'h0004FFF1, 32'hFFFF8000};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                a = va[i]; b = vb[i]; in_valid = 1'b1; in_signed = (i != 2);
            end else begin
                in_valid = 1'b0; in_signed = 1'b0;
            end
            step();
            if (i >= 3 && i < 7) begin
                check("t6_ov", 64'(out_valid), 64'd1);
                check("t6_p",  64'(p),         64'(vp[i-3]));
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
